pc_fetch_controller: RTL and testbench

// - Sequencer for the 8-bit program counter: fetch, decode, execute, branch.
// - Drives PC IncPC/LoadPC/new_count and the instruction-memory request.
// - Memory address is the PC count output directly; this block never drives it.
// - Fetches one opcode byte per instruction: opcode = byte[7:4], byte[3:0] ignored.
// - Jumps are two bytes: opcode byte, then target-address byte.
// - Sits between the PC, instruction memory and the ALU.

---
 rtl/pc_ctrl_pkg.sv | 29 ++
 rtl/pc_ctrl_watchdog.sv | 40 ++++
 rtl/pc_fetch_controller.sv | 151 +++++++++++++++
 tb/tb_pc_fetch_controller.sv | 479 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_ctrl_pkg.sv
// Shared types and opcode constants for the program-counter fetch sequencer.
// The opcode is the upper nibble of the fetched instruction byte.
package pc_ctrl_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StFetch,
        StIncOp,
        StDecode,
        StExecStart,
        StExecWait,
        StFetchTgt,
        StLoadTgt,
        StIncTgt,
        StHalt,
        StError
    } state_e;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_JMP  = 4'hC;
    localparam logic [3:0] OP_JZ   = 4'hD;
    localparam logic [3:0] OP_JNZ  = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    function automatic logic is_alu_op(input logic [3:0] op);
        return (op >= 4'h1) && (op <= 4'hB);
    endfunction

endpackage

// File: rtl/pc_ctrl_watchdog.sv
// ALU-wait watchdog: cleared on ALU start, counts each enabled wait cycle and
// flags expiry on the cycle whose increment reaches Timeout-1.
module pc_ctrl_watchdog #(
    parameter int unsigned Timeout = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);

    localparam int unsigned TO_W = $clog2(Timeout + 1);
    // Timeout of 1 degenerates to expiring on the first waiting cycle.
    localparam logic [TO_W:0] ExpireAt = (TO_W + 1)'((Timeout > 1) ? Timeout - 1 : 1);

    logic [TO_W-1:0] count_q, count_d;
    logic [TO_W:0]   count_inc;

    assign count_inc = {1'b0, count_q} + (TO_W + 1)'(1);
    assign expire_o  = enable_i && (count_inc >= ExpireAt);

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i) begin
            count_d = count_inc[TO_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/pc_fetch_controller.sv
// Moore sequencer for an 8-bit program counter: fetches opcode bytes, drives
// PC increment/load, launches ALU ops and handles two-byte jumps.
module pc_fetch_controller
    import pc_ctrl_pkg::*;
#(
    parameter int unsigned ALU_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_i,
    input  logic [7:0] mem_rdata_i,
    input  logic       mem_ack_i,
    input  logic       alu_done_i,
    input  logic       zero_flag_i,
    output logic       mem_req_o,
    output logic       pc_inc_o,
    output logic       pc_load_o,
    output logic [7:0] pc_new_count_o,
    output logic       alu_start_o,
    output logic [3:0] alu_op_o,
    output logic       halted_o,
    output logic       error_o
);

    state_e     state_q, state_d;
    logic [3:0] ir_q, ir_d;
    logic [7:0] target_q, target_d;
    logic       taken_q, taken_d;
    logic       wd_clear, wd_enable, wd_expire;

    pc_ctrl_watchdog #(
        .Timeout(ALU_TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clear_i (wd_clear),
        .enable_i(wd_enable),
        .expire_o(wd_expire)
    );

    assign alu_op_o       = ir_q;
    assign pc_new_count_o = target_q;

    always_comb begin
        state_d     = state_q;
        ir_d        = ir_q;
        target_d    = target_q;
        taken_d     = taken_q;
        wd_clear    = 1'b0;
        wd_enable   = 1'b0;
        mem_req_o   = 1'b0;
        pc_inc_o    = 1'b0;
        pc_load_o   = 1'b0;
        alu_start_o = 1'b0;
        halted_o    = 1'b0;
        error_o     = 1'b0;

        case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = StFetch;
                end
            end
            StFetch: begin
                mem_req_o = 1'b1;
                if (mem_ack_i) begin
                    ir_d    = mem_rdata_i[7:4];
                    state_d = StIncOp;
                end
            end
            StIncOp: begin
                pc_inc_o = 1'b1;
                state_d  = StDecode;
            end
            StDecode: begin
                if (ir_q == OP_NOP) begin
                    state_d = StFetch;
                end else if (is_alu_op(ir_q)) begin
                    state_d = StExecStart;
                end else if (ir_q == OP_HALT) begin
                    state_d = StHalt;
                end else begin
                    // Remaining opcodes are the three jump forms.
                    if (ir_q == OP_JMP) begin
                        taken_d = 1'b1;
                    end else if (ir_q == OP_JZ) begin
                        taken_d = zero_flag_i;
                    end else begin
                        taken_d = ~zero_flag_i;
                    end
                    state_d = StFetchTgt;
                end
            end
            StExecStart: begin
                alu_start_o = 1'b1;
                wd_clear    = 1'b1;
                state_d     = StExecWait;
            end
            StExecWait: begin
                // Completion takes priority over a coincident timeout.
                if (alu_done_i) begin
                    state_d = StFetch;
                end else begin
                    wd_enable = 1'b1;
                    if (wd_expire) begin
                        state_d = StError;
                    end
                end
            end
            StFetchTgt: begin
                mem_req_o = 1'b1;
                if (mem_ack_i) begin
                    target_d = mem_rdata_i;
                    state_d  = taken_q ? StLoadTgt : StIncTgt;
                end
            end
            StLoadTgt: begin
                pc_load_o = 1'b1;
                state_d   = StFetch;
            end
            StIncTgt: begin
                pc_inc_o = 1'b1;
                state_d  = StFetch;
            end
            StHalt: begin
                halted_o = 1'b1;
            end
            StError: begin
                error_o = 1'b1;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            ir_q     <= OP_NOP;
            target_q <= '0;
            taken_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            ir_q     <= ir_d;
            target_q <= target_d;
            taken_q  <= taken_d;
        end
    end

endmodule

// File: tb/tb_pc_fetch_controller.sv
// Directed bench: behavioural PC, byte memory with programmable ack latency
// and a hand-driven ALU done line around the fetch controller.
module tb_pc_fetch_controller;

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] mem_rdata;
    logic       mem_ack;
    logic       alu_done;
    logic       zero_flag;
    logic       mem_req;
    logic       pc_inc;
    logic       pc_load;
    logic [7:0] pc_new_count;
    logic       alu_start;
    logic [3:0] alu_op;
    logic       halted;
    logic       error;

    logic [7:0] mem [256];
    logic [7:0] pc;
    logic       pc_rst_n;
    logic       force_ack;
    int         delay;
    int         wait_cnt;

    int checks = 0;
    int errors = 0;

    pc_fetch_controller #(
        .ALU_TIMEOUT(16)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start_i       (start),
        .mem_rdata_i   (mem_rdata),
        .mem_ack_i     (mem_ack),
        .alu_done_i    (alu_done),
        .zero_flag_i   (zero_flag),
        .mem_req_o     (mem_req),
        .pc_inc_o      (pc_inc),
        .pc_load_o     (pc_load),
        .pc_new_count_o(pc_new_count),
        .alu_start_o   (alu_start),
        .alu_op_o      (alu_op),
        .halted_o      (halted),
        .error_o       (error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // PC is owned by the environment and has its own reset.
    always_ff @(posedge clk or negedge pc_rst_n) begin
        if (!pc_rst_n) begin
            pc <= 8'h00;
        end else if (pc_load) begin
            pc <= pc_new_count;
        end else if (pc_inc) begin
            pc <= pc + 8'h01;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_req && !mem_ack) wait_cnt <= wait_cnt + 1;
        else wait_cnt <= 0;
    end

    assign mem_rdata = mem[pc];
    assign mem_ack   = (mem_req && (wait_cnt >= delay)) || force_ack;

    task automatic init_env();
        for (int i = 0; i < 256; i++) mem[i] = 8'hF0;
        delay     = 0;
        force_ack = 1'b0;
        alu_done  = 1'b0;
        zero_flag = 1'b0;
        start     = 1'b0;
        reset     = 1'b0;
        pc_rst_n  = 1'b0;
        @(negedge clk);
        pc_rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic release_and_start();
        reset = 1'b1;
        start = 1'b1;
    endtask

    task automatic run_prog(input int max_cycles, output int incs, output int loads,
                            output int both, output logic [7:0] last_nc);
        incs = 0; loads = 0; both = 0; last_nc = 8'h00;
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            if (pc_inc) incs++;
            if (pc_load) begin
                loads++;
                last_nc = pc_new_count;
            end
            if (pc_inc && pc_load) both++;
            if (halted || error) break;
        end
    endtask

    task automatic test_reset();
        init_env();
        checks++;
        if ({mem_req, pc_inc, pc_load, alu_start, halted, error} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl_outs: got %b expected 000000",
                     {mem_req, pc_inc, pc_load, alu_start, halted, error});
        end
        checks++;
        if (pc_new_count !== 8'h00) begin
            errors++;
            $display("FAIL reset_new_count: got %h expected 00", pc_new_count);
        end
        checks++;
        if (alu_op !== 4'h0) begin
            errors++;
            $display("FAIL reset_alu_op: got %h expected 0", alu_op);
        end
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (mem_req !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_start: mem_req got %b expected 0", mem_req);
        end
    endtask

    task automatic test_nop_halt();
        int inc_mask = 0;
        int halt_cyc = -1;
        init_env();
        mem[0] = 8'h00;
        mem[1] = 8'hF0;
        release_and_start();
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (pc_inc) inc_mask |= (1 << k);
            if (halted && halt_cyc < 0) halt_cyc = k;
        end
        checks++;
        if (inc_mask !== ((1 << 2) | (1 << 5))) begin
            errors++;
            $display("FAIL nop_inc_cycles: got mask %h expected %h", inc_mask, (1 << 2) | (1 << 5));
        end
        checks++;
        if (halt_cyc !== 7) begin
            errors++;
            $display("FAIL nop_halt_cycle: got %0d expected 7", halt_cyc);
        end
        checks++;
        if (pc !== 8'h02) begin
            errors++;
            $display("FAIL nop_pc: got %h expected 02", pc);
        end
        start = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        checks++;
        if (!(halted === 1'b1 && mem_req === 1'b0)) begin
            errors++;
            $display("FAIL halt_absorbing: halted %b mem_req %b expected 1 0", halted, mem_req);
        end
    endtask

    task automatic test_jmp();
        int         loads = 0;
        int         both = 0;
        logic [7:0] nc = 8'h00;
        logic [7:0] pc_at_req = 8'h00;
        bit         seen_load = 0;
        bit         seen_req = 0;
        init_env();
        mem[8'h00] = 8'hC0;
        mem[8'h01] = 8'h40;
        mem[8'h40] = 8'hF0;
        release_and_start();
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (pc_inc && pc_load) both++;
            if (seen_load && !seen_req && mem_req) begin
                seen_req  = 1;
                pc_at_req = pc;
            end
            if (pc_load) begin
                loads++;
                nc = pc_new_count;
                seen_load = 1;
            end
            if (halted) break;
        end
        checks++;
        if (loads !== 1) begin
            errors++;
            $display("FAIL jmp_load_count: got %0d expected 1", loads);
        end
        checks++;
        if (nc !== 8'h40) begin
            errors++;
            $display("FAIL jmp_new_count: got %h expected 40", nc);
        end
        checks++;
        if (!(seen_req && pc_at_req === 8'h40)) begin
            errors++;
            $display("FAIL jmp_refetch_pc: got %h (seen %0d) expected 40", pc_at_req, seen_req);
        end
        checks++;
        if (!(halted === 1'b1 && pc === 8'h41 && both === 0)) begin
            errors++;
            $display("FAIL jmp_end: halted %b pc %h overlap %0d expected 1 41 0", halted, pc, both);
        end
    endtask

    task automatic test_cond_jumps();
        int         incs, loads, both;
        logic [7:0] nc;

        init_env();
        mem[0] = 8'hD0; mem[1] = 8'h77; mem[2] = 8'hF0;
        zero_flag = 1'b0;
        release_and_start();
        run_prog(40, incs, loads, both, nc);
        checks++;
        if (!(pc === 8'h03 && loads === 0 && incs === 3 && halted === 1'b1)) begin
            errors++;
            $display("FAIL jz_not_taken: pc %h loads %0d incs %0d halted %b expected 03 0 3 1",
                     pc, loads, incs, halted);
        end

        init_env();
        mem[8'h00] = 8'hD0; mem[8'h01] = 8'h20; mem[8'h20] = 8'hF0;
        zero_flag = 1'b1;
        release_and_start();
        run_prog(40, incs, loads, both, nc);
        checks++;
        if (!(pc === 8'h21 && loads === 1 && nc === 8'h20 && incs === 2 && both === 0)) begin
            errors++;
            $display("FAIL jz_taken: pc %h loads %0d nc %h incs %0d expected 21 1 20 2",
                     pc, loads, nc, incs);
        end

        init_env();
        mem[8'h00] = 8'hE0; mem[8'h01] = 8'h30; mem[8'h30] = 8'hF0;
        zero_flag = 1'b0;
        release_and_start();
        run_prog(40, incs, loads, both, nc);
        checks++;
        if (!(pc === 8'h31 && loads === 1 && nc === 8'h30)) begin
            errors++;
            $display("FAIL jnz_taken: pc %h loads %0d nc %h expected 31 1 30", pc, loads, nc);
        end

        init_env();
        mem[0] = 8'hE0; mem[1] = 8'h30; mem[2] = 8'hF0;
        zero_flag = 1'b1;
        release_and_start();
        run_prog(40, incs, loads, both, nc);
        checks++;
        if (!(pc === 8'h03 && loads === 0)) begin
            errors++;
            $display("FAIL jnz_not_taken: pc %h loads %0d expected 03 0", pc, loads);
        end
    endtask

    task automatic find_alu_start(input string name, output bit found);
        found = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (alu_start) begin
                found = 1;
                break;
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL %s_alu_start: got none expected pulse within 20 cycles", name);
        end
    endtask

    task automatic test_alu();
        bit found;
        bit double_start = 0;
        init_env();
        mem[0] = 8'h30;
        mem[1] = 8'hF0;
        release_and_start();
        find_alu_start("alu", found);
        checks++;
        if (alu_op !== 4'h3) begin
            errors++;
            $display("FAIL alu_op: got %h expected 3", alu_op);
        end
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (alu_start) double_start = 1;
        end
        alu_done = 1'b1;
        @(negedge clk);
        alu_done = 1'b0;
        checks++;
        if (!(mem_req === 1'b1 && error === 1'b0 && !double_start)) begin
            errors++;
            $display("FAIL alu_done_refetch: mem_req %b error %b dbl %0d expected 1 0 0",
                     mem_req, error, double_start);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (!(halted === 1'b1 && pc === 8'h02)) begin
            errors++;
            $display("FAIL alu_then_halt: halted %b pc %h expected 1 02", halted, pc);
        end
    endtask

    task automatic test_alu_timeout();
        bit found;
        int first_err = -1;
        init_env();
        mem[0] = 8'h50;
        release_and_start();
        find_alu_start("timeout", found);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (error && first_err < 0) first_err = k;
        end
        checks++;
        if (first_err !== 16) begin
            errors++;
            $display("FAIL timeout_cycle: got %0d expected 16", first_err);
        end
        start = 1'b0;
        alu_done = 1'b1;
        @(negedge clk);
        start = 1'b1;
        alu_done = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (!(error === 1'b1 && halted === 1'b0 && mem_req === 1'b0)) begin
            errors++;
            $display("FAIL error_sticky: error %b halted %b mem_req %b expected 1 0 0",
                     error, halted, mem_req);
        end

        init_env();
        mem[0] = 8'h50;
        mem[1] = 8'hF0;
        release_and_start();
        find_alu_start("expiry_race", found);
        repeat (15) @(negedge clk);
        alu_done = 1'b1;
        @(negedge clk);
        alu_done = 1'b0;
        checks++;
        if (!(error === 1'b0 && mem_req === 1'b1)) begin
            errors++;
            $display("FAIL done_beats_expiry: error %b mem_req %b expected 0 1", error, mem_req);
        end
    endtask

    task automatic test_mem_wait();
        int run1 = 0;
        int run2 = 0;
        bit early = 0;
        init_env();
        mem[0] = 8'h00;
        mem[1] = 8'hF0;
        delay = 7;
        release_and_start();
        @(negedge clk);
        for (int i = 0; i < 20 && mem_req; i++) begin
            if (pc_inc) early = 1;
            run1++;
            @(negedge clk);
        end
        checks++;
        if (!(run1 === 8 && !early)) begin
            errors++;
            $display("FAIL wait_req_len: got %0d early %0d expected 8 0", run1, early);
        end
        checks++;
        if (pc_inc !== 1'b1) begin
            errors++;
            $display("FAIL wait_inc_after_ack: got %b expected 1", pc_inc);
        end
        @(negedge clk);
        force_ack = 1'b1;
        @(negedge clk);
        force_ack = 1'b0;
        checks++;
        if (!(mem_req === 1'b1 && pc === 8'h01)) begin
            errors++;
            $display("FAIL spurious_ack: mem_req %b pc %h expected 1 01", mem_req, pc);
        end
        for (int i = 0; i < 20 && mem_req; i++) begin
            run2++;
            @(negedge clk);
        end
        checks++;
        if (run2 !== 8) begin
            errors++;
            $display("FAIL wait_req_len2: got %0d expected 8", run2);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (!(halted === 1'b1 && pc === 8'h02)) begin
            errors++;
            $display("FAIL wait_halt: halted %b pc %h expected 1 02", halted, pc);
        end
    endtask

    task automatic test_reset_mid();
        bit seen_inc = 0;
        init_env();
        mem[0] = 8'hC0;
        mem[1] = 8'h80;
        delay = 5;
        release_and_start();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (pc_inc) begin
                seen_inc = 1;
                break;
            end
        end
        repeat (3) @(negedge clk);
        checks++;
        if (!(seen_inc && mem_req === 1'b1 && alu_op === 4'hC)) begin
            errors++;
            $display("FAIL mid_tgt_setup: inc %0d mem_req %b op %h expected 1 1 c",
                     seen_inc, mem_req, alu_op);
        end
        #1 reset = 1'b0;
        #1;
        checks++;
        if ({mem_req, pc_inc, pc_load, alu_start, halted, error, alu_op, pc_new_count}
            !== 18'b0) begin
            errors++;
            $display("FAIL async_reset_outs: got %h expected 0",
                     {mem_req, pc_inc, pc_load, alu_start, halted, error, alu_op, pc_new_count});
        end
        @(negedge clk);
        delay = 0;
        release_and_start();
        @(negedge clk);
        checks++;
        if (!(mem_req === 1'b1 && pc === 8'h01)) begin
            errors++;
            $display("FAIL refetch_after_reset: mem_req %b pc %h expected 1 01", mem_req, pc);
        end
    endtask

    initial begin
        test_reset();
        test_nop_halt();
        test_jmp();
        test_cond_jumps();
        test_alu();
        test_alu_timeout();
        test_mem_wait();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL sim_timeout: got no completion expected finish before 200000");
        $fatal(1);
    end

endmodule
